// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// mem_pkg : shared FSM state, op encodings and word-offset width for mem_responder
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int WORD_OFFSET_BITS = 2;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_responder_if.sv
//------------------------------------------------------------------------------
// mem_responder_if : controller <-> memory strobe/data bundle
// Optional MemErr signal present only when MEM_ALIGN_CHECK_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic              MemBusy;
`ifdef MEM_ALIGN_CHECK_EN
  logic              MemErr;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  MemData, MemReady, MemBusy, MemErr
  );
  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output MemData, MemReady, MemBusy, MemErr
  );
`else
  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  MemData, MemReady, MemBusy
  );
  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output MemData, MemReady, MemBusy
  );
`endif

endinterface : mem_responder_if

`default_nettype wire

// File: rtl/mem_array.sv
//------------------------------------------------------------------------------
// mem_array : single-port synchronous RAM, registered read, no reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  wire logic                  clk,
  input  wire logic                  we,
  input  wire logic [DEPTH_LOG2-1:0] idx,
  input  wire logic [DATA_W-1:0]     wdata,
  output logic      [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule : mem_array

`default_nettype wire

// File: rtl/mem_responder.sv
//------------------------------------------------------------------------------
// mem_responder : unified word RAM serving multicycle fetch/lw/sw with fixed latency
// Optional alignment check enabled by MEM_ALIGN_CHECK_EN (adds MemErr).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mem_responder_if.slave   bus
);

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_op;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_mem_data;

  logic                  w_req;
  logic                  w_err;
  logic                  w_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_W-1:0]     w_rdata;

  assign w_req = bus.MemRead | bus.MemWrite;

  // RAM index follows the live address while idle so the registered read
  // data for the new request is already valid by the DONE cycle, even at LATENCY=1.
  assign w_idx = (r_state == IDLE)
               ? bus.Addr[DEPTH_LOG2+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS]
               : r_idx;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (r_state == IDLE && w_req) begin
      r_misalign <= |bus.Addr[WORD_OFFSET_BITS-1:0];
    end
  end

  assign w_err      = r_misalign;
  assign bus.MemErr = (r_state == DONE) && r_misalign;
`else
  assign w_err = 1'b0;
`endif

  assign w_we = (r_state == DONE) && (r_op == OP_WR) && !w_err;

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (w_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  // r_cnt holds the number of WAIT cycles still to run, including the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_op       <= OP_RD;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_op    <= bus.MemWrite ? OP_WR : OP_RD;
            r_idx   <= w_idx;
            r_wdata <= bus.WriteData;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_op == OP_RD && !w_err) begin
            r_mem_data <= w_rdata;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MemData  = r_mem_data;
  assign bus.MemReady = (r_state == DONE);
  assign bus.MemBusy  = (r_state != IDLE);

endmodule : mem_responder

`default_nettype wire

// File: tb/tb_mem_responder.sv
//------------------------------------------------------------------------------
// tb_mem_responder : randomized scoreboard bench for mem_responder (LATENCY=2)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_responder;

  localparam int LATENCY    = 2;
  localparam int DEPTH_LOG2 = 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst_n;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_responder #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  exp_t        sb [$];
  logic [31:0] exp_md  = '0;
  bit          pend    = 1'b0;
  logic [31:0] pend_d  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one scoreboard entry per MemReady pulse; read data is due one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_ready", {31'd0, bus.MemReady}, 32'd0);
      chk("rst_busy",  {31'd0, bus.MemBusy},  32'd0);
      chk("rst_data",  bus.MemData, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
      chk("rst_err",   {31'd0, bus.MemErr},   32'd0);
`endif
      sb.delete();
      pend   = 1'b0;
      exp_md = '0;
    end else begin
      if (pend) begin
        chk("read_data", bus.MemData, pend_d);
        exp_md = pend_d;
        pend   = 1'b0;
      end else begin
        chk("data_hold", bus.MemData, exp_md);
      end
      if (bus.MemReady) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got MemReady=1 expected no pending access at %0t", $time);
        end else begin
          e = sb.pop_front();
`ifdef MEM_ALIGN_CHECK_EN
          chk("memerr", {31'd0, bus.MemErr}, {31'd0, e.err});
`endif
          if (e.rd) begin
            pend   = 1'b1;
            pend_d = e.d;
          end
        end
      end
`ifdef MEM_ALIGN_CHECK_EN
      else begin
        chk("memerr_idle", {31'd0, bus.MemErr}, 32'd0);
      end
`endif
    end
  end

  // Issue one access at a negedge with the DUT idle; optionally disturb the strobes while busy.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit perturb);
    exp_t e;
    int   idx;
    int   busy_cycles;
    int   lat;
    bit   seen;
    idx   = int'((addr >> 2) % DEPTH);
    e.err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    e.err = (addr[1:0] != 2'b00);
`endif
    e.rd = 1'b0;
    e.d  = '0;
    if (wr) begin
      if (!e.err) model[idx] = data;
    end else if (!e.err) begin
      e.rd = 1'b1;
      e.d  = model[idx];
    end
    sb.push_back(e);

    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.Addr      = addr;
    bus.WriteData = data;
    busy_cycles   = 0;
    lat           = 0;
    seen          = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.MemBusy) busy_cycles++;
      if (perturb && n == 1) begin
        bus.Addr      = 32'h20;
        bus.MemWrite  = 1'b1;
        bus.WriteData = $urandom;
      end
      if (bus.MemReady) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got no MemReady expected one within 40 cycles at %0t", $time);
    end else begin
      chk("ready_latency", lat, LATENCY);
      chk("busy_cycles", busy_cycles, LATENCY);
    end
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    rst_n         = 1'b1;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) begin
      do_access(1'b0, 1'b1, 32'(i << 2), $urandom, 1'b0);
    end

    // Reset in WAIT drops the pending write.
    bus.MemWrite  = 1'b1;
    bus.Addr      = 32'h10;
    bus.WriteData = 32'hDEADBEEF;
    @(negedge clk);
    chk("busy_before_rst", {31'd0, bus.MemBusy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, bus.MemReady}, 32'd0);
    chk("rst_async_busy",  {31'd0, bus.MemBusy},  32'd0);
    bus.MemWrite = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 32'h10, '0, 1'b0);
    chk("rst_dropped_write", bus.MemData, model[4]);

    do_access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0);
    do_access(1'b1, 1'b0, 32'h40, '0, 1'b0);
    chk("raw_0x40", bus.MemData, 32'hCAFEF00D);

    do_access(1'b1, 1'b1, 32'h8, 32'h12345678, 1'b0);
    chk("both_keeps_data", bus.MemData, 32'hCAFEF00D);
    do_access(1'b1, 1'b0, 32'h8, '0, 1'b0);
    chk("both_write_wins", bus.MemData, 32'h12345678);

    do_access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0);
    do_access(1'b1, 1'b0, 32'h000, '0, 1'b0);
    chk("wrap_0x400", bus.MemData, 32'hA5A5A5A5);

    do_access(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0);
    do_access(1'b1, 1'b0, 32'h40, '0, 1'b1);
    chk("busy_ignore_read", bus.MemData, 32'hCAFEF00D);
    do_access(1'b1, 1'b0, 32'h20, '0, 1'b0);
    chk("busy_ignore_0x20", bus.MemData, 32'h11111111);

`ifdef MEM_ALIGN_CHECK_EN
    do_access(1'b0, 1'b1, 32'h42, 32'hBAD0BAD0, 1'b0);
    do_access(1'b1, 1'b0, 32'h40, '0, 1'b0);
    chk("misaligned_no_write", bus.MemData, 32'hCAFEF00D);
`endif

    for (int i = 0; i < 200; i++) begin
      a   = $urandom_range(0, 4095);
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    do_access(1'b1, 1'b0, a, $urandom, 1'b0);
        2:       do_access(1'b0, 1'b1, a, $urandom, 1'b0);
        default: do_access(1'b1, 1'b1, a, $urandom, 1'b0);
      endcase
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_responder

`default_nettype wire
